// File: rtl/prod_accum_pkg.sv
// rtl/prod_accum_pkg.sv - shared constants and FSM state encoding for prod_accum
//   PROD_W  : width of one product from the upstream 4x4 multiplier
//   state_t : ST_ACCUM (summing a batch), ST_HOLD (completed batch on output)
package prod_accum_pkg;

  localparam int PROD_W = 8;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/prod_accum_edge_det.sv
// rtl/prod_accum_edge_det.sv - rising-edge detector for the multiplier done flag
//   clk  : clock
//   rst  : synchronous active-low reset; clears the sampled history to 0
//   d    : level or pulse input
//   rise : high while d is 1 and the previous registered sample was 0
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev <= 1'b0;
    end else begin
      prev <= d;
    end
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/prod_accum.sv
// rtl/prod_accum.sv - sums BATCH products into one registered result with a valid/ready hold
//   Parameters: ACC_W (result width, 8..16), BATCH (products per result, 1..16)
//   clk, rst      : clock, synchronous active-low reset
//   z_in, z_done  : product and its done flag; each 0->1 of z_done accepts one product
//   clr           : synchronous clear of the batch in progress, highest priority
//   out_ready     : consumer takes acc_out while acc_valid is high
//   acc_out       : running partial sum in ACCUM, completed sum in HOLD
//   acc_valid     : acc_out holds a completed batch
//   cnt           : products accepted into the current batch
//   drop_err      : sticky, a product was lost (cleared by rst or clr)
//   Build option PROD_ACCUM_SAT_EN: saturate on overflow and flag drop_err;
//   without it the accumulator wraps silently.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int ACC_W = 12,
  parameter int BATCH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] z_in,
  input  logic              z_done,
  input  logic              clr,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  output logic [4:0]        cnt,
  output logic              drop_err
);

  localparam logic [4:0] BATCH_CNT = 5'(BATCH);

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [4:0]       cnt_q, cnt_nx;
  logic             drop, drop_nx;
  logic             accept;
  logic [ACC_W-1:0] z_ext;

  edge_det u_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (z_done),
    .rise (accept)
  );

  assign z_ext = ACC_W'(z_in);

`ifdef PROD_ACCUM_SAT_EN
  logic [ACC_W:0] sum;
  assign sum = {1'b0, acc} + {1'b0, z_ext};
`endif

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt_q;
    drop_nx  = drop;
    if (clr) begin
      // Clear wins over everything, including a same-cycle accept.
      state_nx = ST_ACCUM;
      acc_nx   = '0;
      cnt_nx   = '0;
      drop_nx  = 1'b0;
    end else begin
      unique case (state)
        ST_ACCUM: begin
          if (accept) begin
`ifdef PROD_ACCUM_SAT_EN
            if (sum[ACC_W]) begin
              acc_nx  = '1;
              drop_nx = 1'b1;
            end else begin
              acc_nx = sum[ACC_W-1:0];
            end
`else
            acc_nx = acc + z_ext;
`endif
            cnt_nx = cnt_q + 5'd1;
            if (cnt_nx == BATCH_CNT) begin
              state_nx = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            if (accept) begin
              // The product arriving on the handshake seeds the next batch.
              // With a one-product batch that seed is itself a complete batch.
              acc_nx   = z_ext;
              cnt_nx   = 5'd1;
              state_nx = (BATCH_CNT == 5'd1) ? ST_HOLD : ST_ACCUM;
            end else begin
              acc_nx   = '0;
              cnt_nx   = '0;
              state_nx = ST_ACCUM;
            end
          end else if (accept) begin
            drop_nx = 1'b1;
          end
        end
        default: state_nx = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_ACCUM;
      acc   <= '0;
      cnt_q <= '0;
      drop  <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt_q <= cnt_nx;
      drop  <= drop_nx;
    end
  end

  assign acc_out   = acc;
  assign cnt       = cnt_q;
  assign acc_valid = (state == ST_HOLD);
  assign drop_err  = drop;

endmodule

// File: tb/tb_prod_accum.sv
// tb/tb_prod_accum.sv - scoreboard bench for prod_accum (default build and an ACC_W=8, BATCH=2 build)
module tb_prod_accum;

  typedef struct {
    int acc;
    int cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  z_a = 8'd0;
  logic        zd_a = 1'b0;
  logic [7:0]  z_b = 8'd0;
  logic        zd_b = 1'b0;

  logic [11:0] acc_a;
  logic        val_a;
  logic [4:0]  cnt_a;
  logic        drop_a;
  logic [7:0]  acc_b;
  logic        val_b;
  logic [4:0]  cnt_b;
  logic        drop_b;

  int checks = 0;
  int errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic prev_va = 1'b0;
  logic prev_vb = 1'b0;

  prod_accum u_a (
    .clk(clk), .rst(rst), .z_in(z_a), .z_done(zd_a), .clr(clr), .out_ready(out_ready),
    .acc_out(acc_a), .acc_valid(val_a), .cnt(cnt_a), .drop_err(drop_a)
  );

  prod_accum #(.ACC_W(8), .BATCH(2)) u_b (
    .clk(clk), .rst(rst), .z_in(z_b), .z_done(zd_b), .clr(clr), .out_ready(out_ready),
    .acc_out(acc_b), .acc_valid(val_b), .cnt(cnt_b), .drop_err(drop_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int sel, input int p);
    if (sel == 0) begin z_a = 8'(p); zd_a = 1'b1; end
    else          begin z_b = 8'(p); zd_b = 1'b1; end
    step();
    zd_a = 1'b0;
    zd_b = 1'b0;
    step();
  endtask

  task automatic push_a(input int acc, input int cnt);
    exp_t e;
    e.acc = acc; e.cnt = cnt;
    qa.push_back(e);
  endtask

  // Monitors: each newly presented completed batch is compared against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst && val_a && !prev_va) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL mon_a_unexpected: got acc %0d cnt %0d expected no result", acc_a, cnt_a);
      end else begin
        e = qa.pop_front();
        chk("mon_a_acc", int'(acc_a), e.acc);
        chk("mon_a_cnt", int'(cnt_a), e.cnt);
      end
    end
    prev_va <= val_a;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && val_b && !prev_vb) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL mon_b_unexpected: got acc %0d cnt %0d expected no result", acc_b, cnt_b);
      end else begin
        e = qb.pop_front();
        chk("mon_b_acc", int'(acc_b), e.acc);
        chk("mon_b_cnt", int'(cnt_b), e.cnt);
      end
    end
    prev_vb <= val_b;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t eb;
    // Reset state
    step(); step();
    chk("rst_acc", int'(acc_a), 0);
    chk("rst_cnt", int'(cnt_a), 0);
    chk("rst_valid", int'(val_a), 0);
    chk("rst_drop", int'(drop_a), 0);
    rst = 1'b1;
    step();

    // Batch 15+30+225+100 held while out_ready is low
    push_a(370, 4);
    put(0, 15);
    chk("partial_acc", int'(acc_a), 15);
    chk("partial_cnt", int'(cnt_a), 1);
    put(0, 30); put(0, 225); put(0, 100);
    chk("full_valid", int'(val_a), 1);
    chk("full_acc", int'(acc_a), 370);
    chk("full_cnt", int'(cnt_a), 4);
    step(); step(); step();
    chk("hold_valid", int'(val_a), 1);
    chk("hold_acc", int'(acc_a), 370);
    chk("hold_cnt", int'(cnt_a), 4);

    // Handshake with a same-cycle product seeds the next batch
    z_a = 8'd9; zd_a = 1'b1; out_ready = 1'b1;
    step();
    zd_a = 1'b0; out_ready = 1'b0;
    chk("seed_valid", int'(val_a), 0);
    chk("seed_acc", int'(acc_a), 9);
    chk("seed_cnt", int'(cnt_a), 1);
    step();
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr1_acc", int'(acc_a), 0);
    chk("clr1_cnt", int'(cnt_a), 0);

    // Level-held done flag gives one accept
    z_a = 8'd50; zd_a = 1'b1;
    repeat (10) step();
    zd_a = 1'b0; step();
    chk("level_acc", int'(acc_a), 50);
    chk("level_cnt", int'(cnt_a), 1);
    clr = 1'b1; step(); clr = 1'b0;

    // Drop in HOLD, then clear
    push_a(10, 4);
    put(0, 1); put(0, 2); put(0, 3); put(0, 4);
    put(0, 77);
    chk("drop_flag", int'(drop_a), 1);
    chk("drop_acc", int'(acc_a), 10);
    chk("drop_valid", int'(val_a), 1);
    step(); step();
    chk("drop_sticky", int'(drop_a), 1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr2_acc", int'(acc_a), 0);
    chk("clr2_cnt", int'(cnt_a), 0);
    chk("clr2_valid", int'(val_a), 0);
    chk("clr2_drop", int'(drop_a), 0);

    // Reset mid-batch, then a fresh batch
    put(0, 5); put(0, 6);
    rst = 1'b0; step();
    chk("midrst_acc", int'(acc_a), 0);
    chk("midrst_cnt", int'(cnt_a), 0);
    chk("midrst_valid", int'(val_a), 0);
    rst = 1'b1; step();
    push_a(100, 4);
    put(0, 10); put(0, 20); put(0, 30); put(0, 40);
    chk("fresh_acc", int'(acc_a), 100);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("ack_valid", int'(val_a), 0);
    chk("ack_acc", int'(acc_a), 0);
    chk("ack_cnt", int'(cnt_a), 0);

    // Overflow on the narrow instance: 200 + 100
`ifdef PROD_ACCUM_SAT_EN
    eb.acc = 255;
`else
    eb.acc = 44;
`endif
    eb.cnt = 2;
    qb.push_back(eb);
    put(1, 200); put(1, 100);
    chk("ovf_valid", int'(val_b), 1);
`ifdef PROD_ACCUM_SAT_EN
    chk("ovf_drop", int'(drop_b), 1);
`else
    chk("ovf_drop", int'(drop_b), 0);
`endif
    step(); step();

    chk("sb_a_empty", qa.size(), 0);
    chk("sb_b_empty", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 Parameter: ACC_W, default 12, accumulator/result width in bits (legal range 8..16).
REQ-002 Parameter: BATCH, default 4, number of products summed per result (legal range 1..16).
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-low; sampled on the rising clk edge.
REQ-005 Port: z_in  input  8  product from the upstream 4-bit sequential multiplier.
REQ-006 Port: z_done  input  1  multiplier done flag; a product is taken on each 0->1 transition, pulse or level.
REQ-007 Port: clr  input  1  synchronous clear of the batch in progress.
REQ-008 Port: out_ready  input  1  consumer accepts acc_out while acc_valid=1.
REQ-009 Port: acc_out  output  ACC_W  batch sum, registered.
REQ-010 Port: acc_valid  output  1  acc_out holds a completed batch.
REQ-011 Port: cnt  output  5  products accepted into the current batch.
REQ-012 Port: drop_err  output  1  sticky flag; a product was lost.

Function
REQ-013 Product accept event SHALL be z_done high this cycle and low in the previous registered sample; the first sample after reset SHALL be treated as low.
REQ-014 FSM SHALL have two states: ACCUM and HOLD.
REQ-015 In ACCUM, each accept event SHALL add zero-extended z_in to the accumulator and increment cnt on the same edge, with a latency of 1 cycle.
REQ-016 The accept event that makes cnt reach BATCH SHALL move the FSM to HOLD and set acc_valid on that edge.
REQ-017 In HOLD, acc_out and cnt SHALL be stable; acc_valid SHALL stay 1 until out_ready=1.
REQ-018 HOLD with out_ready=1 SHALL return the FSM to ACCUM, clear acc_valid, and zero acc and cnt.
REQ-019 HOLD with out_ready=1 and a same-cycle accept event SHALL load acc=z_in and cnt=1, so the product starts the next batch.
REQ-020 An accept event in HOLD with out_ready=0 SHALL drop the product and set drop_err.
REQ-021 clr=1 SHALL zero acc and cnt, clear acc_valid, force ACCUM, and discard any same-cycle accept event; clr SHALL take priority over all other events.
REQ-022 drop_err SHALL clear only on reset or clr.
REQ-023 With BATCH=1, every accept event in ACCUM SHALL move the FSM directly to HOLD.
REQ-024 In ACCUM, acc_out SHALL present the running partial sum.

Reset
REQ-025 rst=0 at a clk edge SHALL set acc_out=0, cnt=0, acc_valid=0, drop_err=0, state=ACCUM, and the edge-detect register to 0, regardless of the state in progress.
REQ-026 Reset mid-batch SHALL discard the partial sum without any output pulse.

Configuration
REQ-027 Macro PROD_ACCUM_SAT_EN SHALL select the overflow behaviour.
REQ-028 With PROD_ACCUM_SAT_EN defined, an addition exceeding 2^ACC_W-1 SHALL clamp acc to all-ones and set drop_err.
REQ-029 Without PROD_ACCUM_SAT_EN, addition SHALL wrap modulo 2^ACC_W and SHALL NOT set drop_err.

Structure
REQ-030 A shared package SHALL hold PROD_W=8 and the FSM state encodings ST_ACCUM=0 and ST_HOLD=1.
REQ-031 The rising-edge detector SHALL be a separate sub-module, edge_det (inputs clk, rst, d; output rise).
REQ-032 The top module SHALL contain only the FSM, accumulator and counter.

Verification
REQ-033 Defaults; products 15,30,225,100 each on a z_done pulse; out_ready=0 -> acc_out=370, acc_valid=1, cnt=4, held stable.
REQ-034 Repeat REQ-033, then raise out_ready in the same cycle as a z_done edge with z_in=9 -> acc_valid=0, acc_out=9, cnt=1 on the next edge.
REQ-035 z_done held high for 10 cycles with z_in=50 -> exactly one accept, acc_out=50, cnt=1.
REQ-036 In HOLD, a z_done edge with out_ready=0 -> drop_err=1 and acc_out unchanged; then clr=1 -> all outputs 0.
REQ-037 ACC_W=8, BATCH=2, products 200 and 100 -> with PROD_ACCUM_SAT_EN: acc_out=255 and drop_err=1; without it: acc_out=44 and drop_err=0.
REQ-038 rst=0 asserted after two of four products -> outputs 0 on the next edge; a fresh batch then sums correctly from 0.
